// File: rtl/captura_solicitudes.sv
// captura_solicitudes: synchronises, debounces and latches floor requests.
// Presents the pending vector with a one-cycle load strobe on any change.
module captura_solicitudes #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [9:0]  VALID_MASK      = 10'b1011111101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] btn,
    input  logic [9:0] clr_req,
    output logic [9:0] ParallelIn,
    output logic       load,
    output logic       any_pending
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [9:0]    sync1_q, sync1_d;
    logic [9:0]    sync2_q, sync2_d;
    logic [CW-1:0] cnt_q [10];
    logic [CW-1:0] cnt_d [10];
    logic [9:0]    deb_q, deb_d;
    logic [9:0]    press;
    logic [9:0]    pend_q, pend_d;
    logic          load_q, load_d;

    // two-flop synchroniser chain for the raw buttons
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    // per-bit debounce: count mismatch run, accept level after the full run
    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < 10; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // pending set on press, clear wins, absent bits forced low
    always_comb begin
        pend_d = (pend_q | press) & ~clr_req & VALID_MASK;
        load_d = (pend_d != pend_q);
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pend_q  <= '0;
            load_q  <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ParallelIn  = pend_q;
    assign load        = load_q;
    assign any_pending = |pend_q;

endmodule

// File: tb/tb_captura_solicitudes.sv
// tb_captura_solicitudes: randomized and directed checks of request capture.
// Reference model uses a window of synchronised levels per edge.
module tb_captura_solicitudes;

    localparam int D = 4;
    localparam logic [9:0] MASK = 10'b1011111101;

    logic       clk;
    logic       rst_n;
    logic [9:0] btn;
    logic [9:0] clr_req;
    logic [9:0] ParallelIn;
    logic       load;
    logic       any_pending;

    int checks = 0;
    int errs   = 0;

    logic [9:0] m_r1, m_r2, m_deb, m_pend;
    logic       m_load;
    logic [9:0] m_win[$];

    captura_solicitudes #(
        .DEBOUNCE_CYCLES(D),
        .VALID_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .clr_req(clr_req),
        .ParallelIn(ParallelIn),
        .load(load),
        .any_pending(any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_r1 = '0;
        m_r2 = '0;
        m_deb = '0;
        m_pend = '0;
        m_load = 1'b0;
        m_win.delete();
    endtask

    // Level seen by debounce is btn from two edges ago; a bit flips when
    // the last D seen levels all disagree with its accepted level.
    task automatic model_edge();
        logic [9:0] pr, nxt;
        bit all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_win.push_back(m_r2);
        if (m_win.size() > D) void'(m_win.pop_front());
        pr = '0;
        if (m_win.size() == D) begin
            for (int i = 0; i < 10; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (m_win[j][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[i] = ~m_deb[i];
                    pr[i] = m_deb[i];
                end
            end
        end
        nxt = (m_pend | pr) & ~clr_req & MASK;
        m_load = (nxt != m_pend);
        m_pend = nxt;
        m_r2 = m_r1;
        m_r1 = btn;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({ParallelIn, load, any_pending} !== 12'h000) begin
            errs++;
            $display("FAIL reset_async: got pi=%h ld=%b ap=%b want 0",
                     ParallelIn, load, any_pending);
        end
        for (int e = 0; e < 5; e++) begin
            step();
            if (e == 2) begin
                @(negedge clk) rst_n = 1'b1;
            end
            checks++;
            if ({ParallelIn, load, any_pending} !== 12'h000) begin
                errs++;
                $display("FAIL reset_hold: got pi=%h ld=%b ap=%b want 0",
                         ParallelIn, load, any_pending);
            end
        end
    endtask

    task automatic test_basic_press();
        btn = 10'h004;
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if ({ParallelIn, load, any_pending} !==
                {m_pend, m_load, |m_pend}) begin
                errs++;
                $display("FAIL press_model e%0d: got %h/%b want %h/%b",
                         e, ParallelIn, load, m_pend, m_load);
            end
            if (e == 5 || e == 6 || e == 7) begin
                checks++;
                if ({ParallelIn, load, any_pending} !==
                    ((e == 5) ? 12'h000 :
                     (e == 6) ? {10'h004, 2'b11} : {10'h004, 2'b01})) begin
                    errs++;
                    $display("FAIL press_latency e%0d: got pi=%h ld=%b ap=%b",
                             e, ParallelIn, load, any_pending);
                end
            end
        end
        btn = 10'h000;
        for (int e = 0; e < 12; e++) begin
            step();
            checks++;
            if ({ParallelIn, load} !== {10'h004, 1'b0}) begin
                errs++;
                $display("FAIL release_noload: got pi=%h ld=%b want 004/0",
                         ParallelIn, load);
            end
        end
        clr_req = 10'h004;
        step();
        checks++;
        if ({ParallelIn, load, any_pending} !== 12'h002) begin
            errs++;
            $display("FAIL clear_latency: got pi=%h ld=%b ap=%b want 000/1/0",
                     ParallelIn, load, any_pending);
        end
        clr_req = 10'h004;
        step();
        checks++;
        if ({ParallelIn, load} !== 11'h000) begin
            errs++;
            $display("FAIL clear_nonpending: got pi=%h ld=%b want 000/0",
                     ParallelIn, load);
        end
        clr_req = 10'h000;
    endtask

    task automatic test_glitch();
        btn = 10'h020;
        for (int e = 0; e < 13; e++) begin
            if (e == 3) btn = 10'h000;
            step();
            checks++;
            if ({ParallelIn, load} !== 11'h000 || m_load !== 1'b0) begin
                errs++;
                $display("FAIL glitch: got pi=%h ld=%b model_ld=%b want 0",
                         ParallelIn, load, m_load);
            end
        end
    endtask

    task automatic test_masked();
        btn = 10'h102;
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if ({ParallelIn, load, any_pending} !== 12'h000) begin
                errs++;
                $display("FAIL masked: got pi=%h ld=%b ap=%b want 0",
                         ParallelIn, load, any_pending);
            end
        end
        btn = 10'h000;
        repeat (8) step();
    endtask

    task automatic test_clear_vs_press();
        btn = 10'h001;
        repeat (8) step();
        btn = 10'h000;
        repeat (8) step();
        checks++;
        if ({ParallelIn, load} !== {10'h001, 1'b0}) begin
            errs++;
            $display("FAIL cvp_setup: got pi=%h ld=%b want 001/0",
                     ParallelIn, load);
        end
        btn = 10'h001;
        for (int e = 1; e <= 7; e++) begin
            if (e == 6) clr_req = 10'h001;
            if (e == 7) begin
                clr_req = 10'h000;
                btn = 10'h000;
            end
            step();
            checks++;
            if ({ParallelIn, load} !== {m_pend, m_load}) begin
                errs++;
                $display("FAIL cvp_model e%0d: got %h/%b want %h/%b",
                         e, ParallelIn, load, m_pend, m_load);
            end
            if (e == 6) begin
                checks++;
                if ({ParallelIn, load, any_pending} !== 12'h002) begin
                    errs++;
                    $display("FAIL clear_wins: got pi=%h ld=%b ap=%b want 000/1/0",
                             ParallelIn, load, any_pending);
                end
            end
        end
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        btn = 10'h004;
        for (int e = 1; e <= 9; e++) begin
            if (e == 2) btn = 10'h204;
            step();
            checks++;
            if ({ParallelIn, load} !== {m_pend, m_load}) begin
                errs++;
                $display("FAIL b2b_model e%0d: got %h/%b want %h/%b",
                         e, ParallelIn, load, m_pend, m_load);
            end
            if (e >= 6 && e <= 8) begin
                checks++;
                if ({ParallelIn, load} !==
                    ((e == 6) ? {10'h004, 1'b1} :
                     (e == 7) ? {10'h204, 1'b1} : {10'h204, 1'b0})) begin
                    errs++;
                    $display("FAIL b2b e%0d: got pi=%h ld=%b", e, ParallelIn, load);
                end
            end
        end
        btn = 10'h000;
        repeat (8) step();
        clr_req = 10'h204;
        step();
        checks++;
        if ({ParallelIn, load} !== 11'h001) begin
            errs++;
            $display("FAIL multi_clear: got pi=%h ld=%b want 000/1",
                     ParallelIn, load);
        end
        clr_req = 10'h000;
    endtask

    task automatic test_reset_mid();
        btn = 10'h008;
        repeat (3) step();
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({ParallelIn, load, any_pending} !== 12'h000) begin
            errs++;
            $display("FAIL rstmid_async: got pi=%h ld=%b ap=%b want 0",
                     ParallelIn, load, any_pending);
        end
        step();
        @(negedge clk) rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if ({ParallelIn, load} !== {m_pend, m_load}) begin
                errs++;
                $display("FAIL rstmid_model e%0d: got %h/%b want %h/%b",
                         e, ParallelIn, load, m_pend, m_load);
            end
            if (e == 5 || e == 6) begin
                checks++;
                if ({ParallelIn, load} !==
                    ((e == 5) ? 11'h000 : {10'h008, 1'b1})) begin
                    errs++;
                    $display("FAIL rstmid_latency e%0d: got pi=%h ld=%b",
                             e, ParallelIn, load);
                end
            end
        end
        btn = 10'h000;
        repeat (8) step();
        clr_req = 10'h008;
        step();
        clr_req = 10'h000;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                btn = 10'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            clr_req = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'h000;
            step();
            checks++;
            if ({ParallelIn, load, any_pending} !==
                {m_pend, m_load, |m_pend}) begin
                errs++;
                $display("FAIL random n%0d: got %h/%b/%b want %h/%b/%b",
                         n, ParallelIn, load, any_pending,
                         m_pend, m_load, |m_pend);
            end
        end
        btn = 10'h000;
        clr_req = 10'h000;
    endtask

    initial begin
        rst_n = 1'b1;
        btn = 10'h000;
        clr_req = 10'h000;
        model_clear();
        test_reset();
        test_basic_press();
        test_glitch();
        test_masked();
        test_clear_vs_press();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/captura_solicitudes.md
CAPTURA_SOLICITUDES -- requirements
Module: captura_solicitudes

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 16 and set the consecutive stable cycles required to accept a button level change; legal values are 2 to 65535.
REQ-003 Parameter VALID_MASK SHALL default to 10'b1011111101 and mark which request bits exist; floor 0 down and floor 4 up are absent.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the system clock; all logic is rising-edge.
REQ-005 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-006 Port btn SHALL be an input, 10 bits wide, carrying raw asynchronous hall/car buttons; bit 2k is the floor k up request and bit 2k+1 is the floor k down request.
REQ-007 Port clr_req SHALL be an input, 10 bits wide, carrying a synchronous service-clear mask from the controller; each set bit clears that request.
REQ-008 Port ParallelIn SHALL be an output, 10 bits wide, carrying the registered pending-request vector that feeds the request register's parallel input.
REQ-009 Port load SHALL be an output, 1 bit wide, and is a one-cycle strobe meaning ParallelIn changed this cycle and must be loaded downstream.
REQ-010 Port any_pending SHALL be an output, 1 bit wide, and equals the OR of all ParallelIn bits.

Function
REQ-011 Synchronisation: each btn bit SHALL pass through a two-flop synchroniser; nothing downstream of the synchroniser sees raw btn.
REQ-012 Debounce, per bit:
- A counter SHALL count the cycles in which the synchronised level differs from the debounced level.
- The counter SHALL return to 0 in any cycle where the two levels match.
- The debounced level SHALL take the synchronised level on the edge where the mismatch has lasted DEBOUNCE_CYCLES consecutive cycles; the counter returns to 0 on that same edge.
REQ-013 A press event SHALL be the debounced level changing 0->1 and SHALL be computed on the same edge as that update, with no extra cycle of delay.
REQ-014 A release (debounced 1->0) SHALL NOT change the pending state.
REQ-015 Pending-bit update on each edge:
- pending[i] sets on a press event.
- pending[i] clears on clr_req[i].
- Otherwise pending[i] holds.
REQ-016 If a press event and clr_req hit the same bit on the same edge, the clear SHALL win and pending[i] ends at 0.
REQ-017 Bits whose VALID_MASK bit is 0 SHALL read 0 on ParallelIn at all times and SHALL never cause load.
REQ-018 load SHALL be registered and SHALL be 1 in exactly those cycles where ParallelIn differs from its value in the previous cycle; load and the new ParallelIn value appear on the same edge.
REQ-019 The following SHALL produce no load:
- a press on an already-pending bit;
- a clr_req on a non-pending bit;
- a release.
REQ-020 Several bit changes on one edge SHALL produce one load pulse, and ParallelIn SHALL reflect all of them.
REQ-021 Changes on consecutive edges SHALL produce load high on consecutive cycles, and each cycle SHALL carry the updated vector.
REQ-022 Latency:
- btn held stable high, first sampled at edge 1, with the bit not pending and no clr_req: ParallelIn[i]=1 and load=1 SHALL appear after edge 2+DEBOUNCE_CYCLES.
- A clr_req sampled at edge n SHALL show in ParallelIn and load after edge n.
REQ-023 A btn pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL have no effect on any output.

Reset
REQ-024 While rst_n=0, all of the following SHALL be 0 immediately, independent of clk:
- synchroniser flops;
- debounce counters;
- debounced levels;
- pending bits;
- ParallelIn, load and any_pending.
REQ-025 When reset asserts during debounce, the count SHALL be discarded, and after release a button must again be stable for the full DEBOUNCE_CYCLES.
REQ-026 A button held high through reset release SHALL be registered as a new press once the normal latency (REQ-022) has elapsed after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Basic press: btn=10'h004 held from edge 1 -> ParallelIn=10'h004, load=1 for one cycle after edge 6, any_pending=1; then release -> no further load.
REQ-028 Glitch reject: btn[5] high for 3 cycles, then low -> ParallelIn stays 10'h000 and load never asserts.
REQ-029 Masked bits: btn=10'h102 held 20 cycles -> ParallelIn=10'h000 and load=0 throughout.
REQ-030 Clear versus press: pending=10'h001; clr_req=10'h001 on the same edge btn[0]'s press completes debounce -> ParallelIn=10'h000 and load=1 for one cycle.
REQ-031 Consecutive changes: press bit 2 completes at edge k and bit 9 at edge k+1 -> load=1 after k and after k+1, with ParallelIn=10'h004 then 10'h204.
REQ-032 Reset mid-debounce: btn[3] stable 3 cycles, rst_n low 1 cycle, btn still high -> all outputs 0, and ParallelIn=10'h008 appears 6 edges after reset release.
